// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: steers byte/half/word lanes onto a req/ack data bus and stalls the pipeline until the access completes.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of truncating the address.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        ErrM,
    output logic        MisalignM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter only has to reach TIMEOUT_CYCLES-1 (the last REQ cycle before abort).
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             req_q, we_q, err_q, mis_q;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [3:0]       be_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;

    logic        access, byte_acc, half_acc, misalign, trap_now, timeout_hit;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, load_ext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign access = MemReadM | MemWriteM;

    // Size decode: a store wins when both strobes are high; unknown funct3 falls back to word.
    always_comb begin
        byte_acc = 1'b0;
        half_acc = 1'b0;
        if (MemWriteM) begin
            byte_acc = (funct3M == 3'b000);
            half_acc = (funct3M == 3'b001);
        end else begin
            byte_acc = (funct3M == 3'b000) || (funct3M == 3'b100);
            half_acc = (funct3M == 3'b001) || (funct3M == 3'b101);
        end
    end

    always_comb begin
        be_d    = 4'hF;
        wdata_d = WriteDataM;
        if (MemWriteM) begin
            if (byte_acc) begin
                be_d    = 4'b0001 << ALUResultM[1:0];
                wdata_d = {4{WriteDataM[7:0]}};
            end else if (half_acc) begin
                be_d    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{WriteDataM[15:0]}};
            end
        end
    end

    assign misalign    = half_acc ? ALUResultM[0] : (!byte_acc && (ALUResultM[1:0] != 2'b00));
    assign trap_now    = TRAP_EN && misalign;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'b0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'b0, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (access) state_d = trap_now ? S_DONE : S_REQ;
            S_REQ:   if (dmem_ack || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (access && trap_now) begin
                        mis_q   <= 1'b1;
                        rdata_q <= '0;
                    end else if (access) begin
                        req_q   <= 1'b1;
                        we_q    <= MemWriteM;
                        addr_q  <= {ALUResultM[31:2], 2'b00};
                        wdata_q <= wdata_d;
                        be_q    <= be_d;
                        f3_q    <= funct3M;
                        off_q   <= ALUResultM[1:0];
                        cnt_q   <= '0;
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        req_q <= 1'b0;
                        if (!we_q) rdata_q <= load_ext;
                    end else if (timeout_hit) begin
                        req_q   <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign StallM     = !rst && access && (state_q != S_DONE);
    assign ReadDataM  = rdata_q;
    assign ErrM       = err_q;
    assign MisalignM  = mis_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized and directed bench for mem_stage_lsu with a byte-lane memory-slave reference model.
// Honors MISALIGN_TRAP_EN when defined for the build.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, ErrM, MisalignM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .ErrM(ErrM), .MisalignM(MisalignM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: access width in bytes, naturally aligned base lane.
    function automatic int acc_size(input bit st, input logic [2:0] f3);
        if (st) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz, base;
        logic [3:0] be;
        if (!st) return 4'hF;
        sz = acc_size(st, f3);
        base = int'(a[1:0]) - (int'(a[1:0]) % sz);
        for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + sz);
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input bit st, input logic [2:0] f3, input logic [31:0] d);
        int sz;
        logic [31:0] w;
        sz = acc_size(st, f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rw);
        int sz, base;
        longint v, span;
        sz = acc_size(1'b0, f3);
        base = int'(a[1:0]) - (int'(a[1:0]) % sz);
        span = longint'(1) << (8 * sz);
        v = (longint'(rw) >> (8 * base)) % span;
        if (sz < 4 && !f3[2] && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic bit exp_trap(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = acc_size(st, f3);
        return TRAP && (sz > 1) && ((int'(a[1:0]) % sz) != 0);
    endfunction

    // Observations from the most recent transaction (the slave side of the bus lives here).
    int          obs_stall, obs_req, obs_err, obs_mis;
    bit          obs_unstable, obs_timeout;
    logic        obs_we;
    logic [31:0] obs_addr, obs_wdata, obs_rd;
    logic [3:0]  obs_be;

    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rw, input int wait_n);
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = a; WriteDataM = wd;
        obs_stall = 0; obs_req = 0; obs_err = 0; obs_mis = 0;
        obs_unstable = 1'b0; obs_timeout = 1'b1;
        #1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (ErrM) obs_err++;
            if (MisalignM) obs_mis++;
            if (dmem_req) begin
                if (obs_req == 0) begin
                    obs_we = dmem_we; obs_addr = dmem_addr; obs_be = dmem_be; obs_wdata = dmem_wdata;
                end else if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {obs_we, obs_addr, obs_be, obs_wdata}) begin
                    obs_unstable = 1'b1;
                end
                dmem_ack   = (obs_req == wait_n);
                dmem_rdata = dmem_ack ? rw : $urandom;
                obs_req++;
            end else begin
                dmem_ack   = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            if (!StallM) begin
                obs_rd = ReadDataM;
                obs_timeout = 1'b0;
                break;
            end
            obs_stall++;
            @(negedge clk);
            #1;
        end
        if (obs_timeout) begin
            n_checks++; n_errors++;
            $display("FAIL no_completion: access a=%h still stalled after 200 cycles, required completion", a);
        end
        $display("txn rd=%0b wr=%0b f3=%0d a=%h stall=%0d req=%0d rd_data=%h", rd, wr, f3, a, obs_stall, obs_req, obs_rd);
    endtask

    task automatic test_reset();
        rst = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010;
        ALUResultM = 32'h104; WriteDataM = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (StallM !== 1'b0) begin
            n_errors++; $display("FAIL reset_stall: got %b, required 0", StallM);
        end
        n_checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, ReadDataM, ErrM, MisalignM} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h be=%h rd=%h err=%b mis=%b, required all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, ReadDataM, ErrM, MisalignM);
        end
        MemReadM = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        n_checks++;
        if ({obs_we, obs_be, obs_addr, obs_wdata} !== {1'b1, 4'hF, 32'h100, 32'hDEADBEEF}) begin
            n_errors++;
            $display("FAIL sw_bus: we=%b be=%h addr=%h wdata=%h, required we=1 be=f addr=00000100 wdata=deadbeef",
                     obs_we, obs_be, obs_addr, obs_wdata);
        end
        n_checks++;
        if (obs_stall !== 2) begin
            n_errors++; $display("FAIL sw_stall: got %0d stall cycles, required 2", obs_stall);
        end
    endtask

    task automatic test_byte_loads();
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 0);
        n_checks++;
        if (obs_rd !== 32'hFFFFFF80) begin
            n_errors++; $display("FAIL lb_sign: got %h, required ffffff80", obs_rd);
        end
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 1);
        n_checks++;
        if (obs_rd !== 32'h00000080) begin
            n_errors++; $display("FAIL lbu_zero: got %h, required 00000080", obs_rd);
        end
        n_checks++;
        if (obs_stall !== 3 || obs_be !== 4'hF || obs_we !== 1'b0) begin
            n_errors++; $display("FAIL lbu_wait: stall=%0d be=%h we=%b, required stall=3 be=f we=0", obs_stall, obs_be, obs_we);
        end
    endtask

    task automatic test_halfwords();
        run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0);
        n_checks++;
        if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCDABCD) begin
            n_errors++; $display("FAIL sh_lanes: be=%b wdata=%h, required be=1100 wdata=abcdabcd", obs_be, obs_wdata);
        end
        run_access(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'hBEEF0000, 0);
        n_checks++;
        if (obs_rd !== 32'h0000BEEF) begin
            n_errors++; $display("FAIL lhu_zero: got %h, required 0000beef", obs_rd);
        end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 1000);
        n_checks++;
        if (obs_req !== 4 || obs_stall !== 5) begin
            n_errors++; $display("FAIL timeout_len: req cycles=%0d stall=%0d, required 4 and 5", obs_req, obs_stall);
        end
        n_checks++;
        if (obs_err !== 1 || obs_rd !== 32'h0) begin
            n_errors++; $display("FAIL timeout_err: err pulses=%0d rd=%h, required 1 and 00000000", obs_err, obs_rd);
        end
    endtask

    task automatic test_misalign();
        run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h13572468, 0);
        n_checks++;
        if (TRAP) begin
            if (obs_req !== 0 || obs_mis !== 1 || obs_stall !== 1 || obs_rd !== 32'h0) begin
                n_errors++;
                $display("FAIL misalign_trap: req=%0d mis=%0d stall=%0d rd=%h, required 0 1 1 00000000",
                         obs_req, obs_mis, obs_stall, obs_rd);
            end
        end else begin
            if (obs_addr !== 32'h100 || obs_stall !== 2 || obs_rd !== 32'h13572468 || obs_mis !== 0) begin
                n_errors++;
                $display("FAIL misalign_trunc: addr=%h stall=%0d rd=%h mis=%0d, required 00000100 2 13572468 0",
                         obs_addr, obs_stall, obs_rd, obs_mis);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 3'b001, 32'h402, 32'h0, 32'h80010000, 0);
        n_checks++;
        if (obs_rd !== 32'hFFFF8001) begin
            n_errors++; $display("FAIL b2b_lh: got %h, required ffff8001", obs_rd);
        end
        run_access(1'b1, 1'b1, 3'b000, 32'h401, 32'h000000A5, 32'h0, 0);
        n_checks++;
        if (obs_stall !== 2 || obs_we !== 1'b1 || obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5A5A5) begin
            n_errors++;
            $display("FAIL b2b_sb: stall=%0d we=%b be=%b wdata=%h, required 2 1 0010 a5a5a5a5",
                     obs_stall, obs_we, obs_be, obs_wdata);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int          kind, wt;
            bit          st, trap;
            logic [2:0]  f3;
            logic [31:0] a, wd, rw;
            kind = $urandom_range(0, 2);
            wt   = $urandom_range(0, 2);
            f3   = 3'($urandom);
            a    = $urandom; wd = $urandom; rw = $urandom;
            st   = (kind != 0);
            trap = exp_trap(st, f3, a);
            run_access(kind != 1, st, f3, a, wd, rw, wt);
            n_checks++;
            if (trap) begin
                if (obs_req !== 0 || obs_mis !== 1 || obs_stall !== 1 || obs_rd !== 32'h0) begin
                    n_errors++;
                    $display("FAIL rand_trap[%0d]: req=%0d mis=%0d stall=%0d rd=%h, required 0 1 1 00000000",
                             n, obs_req, obs_mis, obs_stall, obs_rd);
                end
            end else begin
                if (obs_stall !== 2 + wt || obs_req !== wt + 1 || obs_unstable || obs_err !== 0 || obs_mis !== 0) begin
                    n_errors++;
                    $display("FAIL rand_timing[%0d]: stall=%0d req=%0d unstable=%0b err=%0d mis=%0d, required %0d %0d 0 0 0",
                             n, obs_stall, obs_req, obs_unstable, obs_err, obs_mis, 2 + wt, wt + 1);
                end
                n_checks++;
                if (obs_we !== st || obs_addr !== {a[31:2], 2'b00} || obs_be !== exp_be(st, f3, a)) begin
                    n_errors++;
                    $display("FAIL rand_bus[%0d]: we=%b addr=%h be=%b, required %b %h %b",
                             n, obs_we, obs_addr, obs_be, st, {a[31:2], 2'b00}, exp_be(st, f3, a));
                end
                n_checks++;
                if (st && obs_wdata !== exp_wdata(st, f3, wd)) begin
                    n_errors++;
                    $display("FAIL rand_wdata[%0d]: got %h, required %h", n, obs_wdata, exp_wdata(st, f3, wd));
                end else if (!st && obs_rd !== exp_load(f3, a, rw)) begin
                    n_errors++;
                    $display("FAIL rand_load[%0d]: got %h, required %h", n, obs_rd, exp_load(f3, a, rw));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h300; dmem_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dmem_req !== 1'b1) begin
            n_errors++; $display("FAIL rstmid_req_up: got %b, required 1", dmem_req);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (dmem_req !== 1'b0 || StallM !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_drop: req=%b stall=%b, required 0 0", dmem_req, StallM);
        end
        @(negedge clk);
        rst = 1'b0; MemReadM = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dmem_req !== 1'b0 || StallM !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_idle: req=%b stall=%b, required 0 0", dmem_req, StallM);
        end
        run_access(1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 0);
        n_checks++;
        if (obs_stall !== 2 || obs_rd !== 32'hCAFEF00D) begin
            n_errors++; $display("FAIL rstmid_restart: stall=%0d rd=%h, required 2 cafef00d", obs_stall, obs_rd);
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_byte_loads();
        test_halfwords();
        test_timeout();
        test_misalign();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
